// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared 5-bit PRBS width, seed, recurrence and checker state type
package lfsr_pkg;
  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b01000;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_t;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[0] ^ s[2], s[4:1]};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones; clr_i wins over inc_i. Ports: clk, rst_n (async low), clr_i, inc_i, count_o.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr_i ? '0 : (inc_i && count_q != '1) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count_o = count_q;
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising PRBS receiver (HUNT/VERIFY/LOCKED) with err_pulse and, under LFSR_CHK_STATS_EN, saturating err/word counters. Ports: clk, rst (async low), sample_en, data_in, clr_cnt -> locked, err_pulse, err_count, word_count.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              clr_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count
);
  chk_state_t state_q, state_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [3:0] match_q, match_d, miss_q, miss_d, match_inc, miss_inc;
  logic err_q, err_d, hit, nz;
  assign hit = data_in == exp_q;
  assign nz = |data_in;
  assign match_inc = match_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    match_d = match_q;
    miss_d = miss_q;
    err_d = 1'b0;
    if (sample_en)
      case (state_q)
        HUNT:
          if (nz) begin
            exp_d = lfsr_next(data_in);
            match_d = '0;
            state_d = VERIFY;
          end
        VERIFY:
          if (hit) begin
            match_d = match_inc;
            exp_d = lfsr_next(data_in);
            if (match_inc == 4'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d = '0;
            end
          end else if (nz) begin
            exp_d = lfsr_next(data_in);
            match_d = '0;
          end else state_d = HUNT;
        LOCKED:
          if (hit) begin
            exp_d = lfsr_next(data_in);
            miss_d = '0;
          end else begin
            // flywheel: keep predicting from our own sequence, never reseed while locked
            err_d = 1'b1;
            exp_d = lfsr_next(exp_q);
            miss_d = miss_inc;
            if (miss_inc == 4'(LOSS_CNT)) state_d = HUNT;
          end
        default: state_d = HUNT;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= HUNT;
      exp_q <= '0;
      match_q <= '0;
      miss_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      match_q <= match_d;
      miss_q <= miss_d;
      err_q <= err_d;
    end
  assign locked = state_q == LOCKED;
  assign err_pulse = err_q;
`ifdef LFSR_CHK_STATS_EN
  logic word_inc;
  assign word_inc = sample_en && state_q == LOCKED;
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst_n(rst), .clr_i(clr_cnt), .inc_i(err_d), .count_o(err_count)
  );
  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk(clk), .rst_n(rst), .clr_i(clr_cnt), .inc_i(word_inc), .count_o(word_count)
  );
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign err_count = '0;
  assign word_count = '0;
`endif
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 5-bit PRBS generator: it accepts the generator's parallel state word once per symbol strobe, self-synchronises to the sequence, and then checks every later word against its own prediction. It reports lock status, per-word error pulses and saturating error/word counters. It sits on the fast system clock, with a strobe marking each divided-clock symbol. It is used for link and self-test of the generator path.

## Interface
Parameters:
- LOCK_CNT, 3: number of consecutive matching words after seeding that are required to declare lock (1..15).
- LOSS_CNT, 3: number of consecutive mismatches while locked that cause a return to hunting (1..15).
- CNT_W, 16: width of the error and word counters.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- sample_en  in  1  one-cycle strobe; data_in is valid this cycle.
- data_in  in  5  received generator state word.
- clr_cnt  in  1  synchronous clear of err_count and word_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse on each mismatching word checked while locked.
- err_count  out  CNT_W  saturating count of mismatches while locked.
- word_count  out  CNT_W  saturating count of words checked while locked.

## Operation
- Sequence recurrence, shared with the generator: next(s) = {s[0]^s[2], s[4:1]}.
  - Maximal length: period 31.
  - 5'b00000 is the lock-up word and is never valid.
- FSM states: HUNT, VERIFY, LOCKED.
  - Registers: expected[4:0], match_cnt, miss_cnt.
- HUNT, on sample_en:
  - data_in != 0: expected <= next(data_in), match_cnt <= 0, go to VERIFY.
  - data_in == 0: stay in HUNT.
- VERIFY, on sample_en:
  - data_in == expected: match_cnt++ and expected <= next(data_in). When match_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt <= 0.
  - Mismatch with nonzero data_in: reseed (expected <= next(data_in), match_cnt <= 0), stay in VERIFY.
  - Mismatch with zero data_in: go to HUNT.
  - No counting and no err_pulse in this state.
- LOCKED, on sample_en:
  - word_count increments.
  - Match: expected <= next(data_in), miss_cnt <= 0.
  - Mismatch (flywheel, no reseed): err_pulse, err_count increments, expected <= next(expected), miss_cnt++. When miss_cnt reaches LOSS_CNT, go to HUNT.
- Cycles without sample_en: no state change, err_pulse low.
- Counters saturate at all-ones and never wrap.
- clr_cnt has priority over an increment in the same cycle; the result is 0.

## Timing
- Reset values:
  - State HUNT; expected = 0; match_cnt = 0; miss_cnt = 0.
  - locked = 0, err_pulse = 0, err_count = 0, word_count = 0.
- All outputs are registered; latency is 1 clk from the sample_en edge to locked, err_pulse and counter updates.
- locked rises on the clock edge that processes the LOCK_CNT-th matching word. It falls on the edge that processes the LOSS_CNT-th consecutive miss; that miss still pulses err_pulse and counts.
- Asserting rst mid-sequence returns everything to reset values immediately; the next sample after release is treated as a HUNT seed.
- sample_en may be asserted on back-to-back cycles; every strobed word is processed.

## Configuration
- LFSR_CHK_STATS_EN defined: err_count and word_count are implemented as specified.
- Undefined:
  - Counter registers are not built; err_count and word_count are tied to 0.
  - clr_cnt is ignored.
  - locked and err_pulse are unchanged.

## Structure
- Shared package lfsr_pkg holds:
  - LFSR_W = 5 and the seed constant 5'b01000.
  - Function lfsr_next(), used by both the generator and the checker.
  - Enum chk_state_t {HUNT, VERIFY, LOCKED}.
- One natural sub-module: sat_counter (width-parameterised, with inc, clr and saturation), instantiated twice.

## Test plan
- Clean lock: the stream 01000, 00100, 10010, 01001, 10100, 11010, 01101, each word on sample_en spaced 5 clk.
  - locked rises 1 clk after the 10010→01001 word is processed (LOCK_CNT=3).
  - err_count stays 0; word_count = 3 after 11010, 01101, ….
- Single corruption while locked: replace 11010 with 11011.
  - One err_pulse; err_count = 1; locked stays 1.
  - The next correct word 01101 matches (flywheel).
- Loss of lock: three consecutive wrong words while locked.
  - Three err_pulses; err_count = 3; locked falls on the third.
  - Re-lock after the seed plus 3 clean words.
- Zero word: 00000 in HUNT keeps HUNT. 00000 in VERIFY returns to HUNT. locked never rises.
- Saturation and clear (CNT_W = 4, sustained errors after lock):
  - err_count sticks at 15.
  - clr_cnt asserted together with a mismatch gives err_count = 0.
  - Repeat with LFSR_CHK_STATS_EN undefined: counters stay 0.
- Reset mid-VERIFY: after 2 matches, pulse rst low.
  - All outputs return to 0 immediately.
  - The next word seeds, and lock requires 3 fresh matches.
